mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port: Clk  input  1  rising-edge clock, sole clock of the block.
REQ-002 SHALL have port: Reset_n  input  1  reset, synchronous to Clk, active-low.
REQ-003 SHALL have port: Start  input  1  request; accepted only in IDLE.
REQ-004 SHALL have port: Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100/101 see Configuration, 11x reserved.
REQ-005 SHALL have port: OperandA  input  32  rs value (multiplicand / dividend).
REQ-006 SHALL have port: OperandB  input  32  rt value (multiplier / divisor).
REQ-007 SHALL have port: Busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port: WriteHiData  output  32  result high word (product[63:32] or remainder).
REQ-009 SHALL have port: WriteLoData  output  32  result low word (product[31:0] or quotient).
REQ-010 SHALL have port: WriteEn  output  1  one-cycle strobe, overwrite HI/LO downstream.
REQ-011 SHALL have port: Madd  output  1  one-cycle strobe, accumulate into HI/LO downstream.
REQ-012 SHALL have port: Msub  output  1  one-cycle strobe, subtract from HI/LO downstream.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX and DONE.
REQ-014 SHALL, in IDLE with Start=1 and Op not 11x, latch Op, |A| and |B| (signed ops) or raw A and B (unsigned ops), record the operand signs, clear the 5-bit iteration counter and go to CALC.
REQ-015 SHALL ignore Start while Busy=1 and ignore Start with Op=11x; no state change, no strobe.
REQ-016 SHALL, in CALC, perform one radix-2 step per cycle (shift-add multiply, restoring divide) for exactly 32 cycles, then go to FIX.
REQ-017 SHALL, in FIX, negate the 64-bit product when the operand signs differ (signed multiply); for signed divide, negate the quotient when the signs differ and negate the remainder when A<0; then go to DONE.
REQ-018 SHALL, in DONE, drive exactly one of WriteEn/Madd/Msub high for that single cycle, then return to IDLE.
REQ-019 SHALL raise the strobe exactly 34 rising edges after the edge that accepted Start; Busy SHALL be high for exactly 34 cycles.
REQ-020 SHALL update WriteHiData/WriteLoData on the edge that enters DONE and hold them until the next DONE.
REQ-021 SHALL, on divide by zero, produce Hi=OperandA and Lo=0xFFFFFFFF with no sign fix-up, the normal 34-cycle latency and a WriteEn strobe.
REQ-022 SHALL return Lo=0x80000000, Hi=0 for DIV 0x80000000 / 0xFFFFFFFF, with no exception.
REQ-023 SHALL, when Start arrives in the cycle DONE is exiting, not accept it; it is accepted on the first IDLE cycle only.

Reset
REQ-024 SHALL, on a Clk edge with Reset_n=0, go to IDLE and set Busy=0, WriteEn=0, Madd=0, Msub=0, WriteHiData=0, WriteLoData=0 and the counter to 0.
REQ-025 SHALL abandon any operation in progress when reset occurs mid-CALC/FIX/DONE; no strobe is issued afterwards.

Configuration
REQ-026 SHALL, when macro MDU_MACC_EN is defined, execute Op=100 as a signed multiply ending in a Madd strobe, and Op=101 as a signed multiply ending in an Msub strobe; WriteEn stays 0 for these ops.
REQ-027 SHALL, when MDU_MACC_EN is not defined, execute Op=100/101 exactly as MULT/MULTU with a WriteEn strobe, and tie Madd and Msub to 0; ports remain present.

Verification
REQ-028 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001, WriteEn single pulse at edge 34, Busy high for 34 cycles.
REQ-029 SHALL cover: MULT 0xFFFFFFFD x 0x00000005 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
REQ-030 SHALL cover: DIV 0xFFFFFFF9 / 0x00000002 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU 7 / 0 -> Hi=0x00000007, Lo=0xFFFFFFFF.
REQ-031 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0x00000000.
REQ-032 SHALL cover: second Start at CALC cycle 5 is ignored (one strobe only); Reset_n=0 at CALC cycle 10 -> Busy=0 next edge, outputs 0, no strobe within 40 cycles.
REQ-033 SHALL cover: with MDU_MACC_EN, Op=101, 2 x 3 -> Msub pulse, Hi=0, Lo=6, WriteEn=0; without the macro the same stimulus -> WriteEn pulse, Msub=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / divide: Start accepted in IDLE, strobe in DONE, 34 busy cycles; Start ignored while Busy.
// MDU_MACC_EN: Op=100/101 finish with Madd/Msub instead of WriteEn (otherwise they act as MULT/MULTU).
module mult_div_unit (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] OperandA,
  input  logic [31:0] OperandB,
  output logic        Busy,
  output logic [31:0] WriteHiData,
  output logic [31:0] WriteLoData,
  output logic        WriteEn,
  output logic        Madd,
  output logic        Msub
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] hi_q, lo_q, opnd_q;
  logic        div_q, sign_a_q, sign_b_q, dz_q;
  logic        busy_q, we_q;
  logic [31:0] hi_out_q, lo_out_q;

  logic        accept, op_div, op_sgn;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum, div_shift;
  logic [31:0] div_sub;
  logic        div_ge;
  logic [31:0] hi_step_d, lo_step_d, fix_hi_d, fix_lo_d;
  logic [63:0] prod, prod_neg;

  assign op_div = (Op[2:1] == 2'b01);
`ifdef MDU_MACC_EN
  assign op_sgn = Op[2] | ~Op[0];
`else
  assign op_sgn = ~Op[0];
`endif
  assign accept = (state_q == IDLE) && Start && !(Op[2] && Op[1]);
  assign a_abs  = (op_sgn && OperandA[31]) ? -OperandA : OperandA;
  assign b_abs  = (op_sgn && OperandB[31]) ? -OperandB : OperandB;

  // hi_q/lo_q hold {partial product, multiplier} or {remainder, dividend/quotient}
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign div_shift = {hi_q, lo_q[31]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_sub   = div_shift[31:0] - opnd_q;
  assign prod      = {hi_q, lo_q};
  assign prod_neg  = -prod;

  always_comb begin
    hi_step_d = mul_sum[32:1];
    lo_step_d = {mul_sum[0], lo_q[31:1]};
    fix_hi_d  = hi_q;
    fix_lo_d  = lo_q;
    if (div_q) begin
      hi_step_d = div_ge ? div_sub : div_shift[31:0];
      lo_step_d = {lo_q[30:0], div_ge};
      // a zero divisor leaves |A| in hi; undoing |.| restores the raw dividend
      fix_hi_d  = sign_a_q ? -hi_q : hi_q;
      fix_lo_d  = ((sign_a_q ^ sign_b_q) && !dz_q) ? -lo_q : lo_q;
    end else if (sign_a_q ^ sign_b_q) begin
      fix_hi_d  = prod_neg[63:32];
      fix_lo_d  = prod_neg[31:0];
    end
  end

`ifdef MDU_MACC_EN
  logic madd_op_q, msub_op_q, madd_q, msub_q;
  assign Madd = madd_q;
  assign Msub = msub_q;
`else
  assign Madd = 1'b0;
  assign Msub = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      opnd_q   <= 32'd0;
      div_q    <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      we_q     <= 1'b0;
      hi_out_q <= 32'd0;
      lo_out_q <= 32'd0;
`ifdef MDU_MACC_EN
      madd_op_q <= 1'b0;
      msub_op_q <= 1'b0;
      madd_q    <= 1'b0;
      msub_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= CALC;
            busy_q   <= 1'b1;
            cnt_q    <= 5'd0;
            div_q    <= op_div;
            sign_a_q <= op_sgn & OperandA[31];
            sign_b_q <= op_sgn & OperandB[31];
            dz_q     <= (OperandB == 32'd0);
            hi_q     <= 32'd0;
            opnd_q   <= op_div ? b_abs : a_abs;
            lo_q     <= op_div ? a_abs : b_abs;
`ifdef MDU_MACC_EN
            madd_op_q <= (Op == 3'b100);
            msub_op_q <= (Op == 3'b101);
`endif
          end
        end
        CALC: begin
          hi_q  <= hi_step_d;
          lo_q  <= lo_step_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= FIX;
        end
        FIX: begin
          state_q  <= DONE;
          hi_out_q <= fix_hi_d;
          lo_out_q <= fix_lo_d;
`ifdef MDU_MACC_EN
          we_q     <= ~(madd_op_q | msub_op_q);
          madd_q   <= madd_op_q;
          msub_q   <= msub_op_q;
`else
          we_q     <= 1'b1;
`endif
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          we_q    <= 1'b0;
`ifdef MDU_MACC_EN
          madd_q  <= 1'b0;
          msub_q  <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy        = busy_q;
  assign WriteEn     = we_q;
  assign WriteHiData = hi_out_q;
  assign WriteLoData = lo_out_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops against an arithmetic model.
module tb_mult_div_unit;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] OperandA = 32'd0;
  logic [31:0] OperandB = 32'd0;
  logic        Busy;
  logic [31:0] WriteHiData, WriteLoData;
  logic        WriteEn, Madd, Msub;

  int checks = 0;
  int errors = 0;

  mult_div_unit dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB), .Busy(Busy),
    .WriteHiData(WriteHiData), .WriteLoData(WriteLoData),
    .WriteEn(WriteEn), .Madd(Madd), .Msub(Msub)
  );

  always #5 Clk = ~Clk;

  // {hi, lo} expected for an operation, from plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    logic signed_mul;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
`ifdef MDU_MACC_EN
    signed_mul = (op == 3'b000) || (op == 3'b100) || (op == 3'b101);
`else
    signed_mul = (op == 3'b000) || (op == 3'b100);
`endif
    if (op == 3'b010 || op == 3'b011) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (op == 3'b010) begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      return {ua % ub, ua / ub} >> 0 == 0 ? 64'd0 : {32'(ua % ub), 32'(ua / ub)};
    end
    if (signed_mul) return sa * sb;
    return ua * ub;
  endfunction

  // 0: WriteEn, 1: Madd, 2: Msub
  function automatic int model_kind(input logic [2:0] op);
`ifdef MDU_MACC_EN
    if (op == 3'b100) return 1;
    if (op == 3'b101) return 2;
`endif
    return op[0] ? 0 : 0;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Issues one op and observes 41 samples (#1 after each edge from the accept edge on).
  // strobe_edge is the edge number at which the strobe value is present (accept edge = 0).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int we_n, output int madd_n, output int msub_n,
                        output int strobe_edge, output int busy_n);
    @(negedge Clk);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(posedge Clk); #1;
    Start = 1'b0;
    we_n = 0; madd_n = 0; msub_n = 0; strobe_edge = -1; busy_n = 0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin @(posedge Clk); #1; end
      if (Busy) busy_n++;
      if (WriteEn) we_n++;
      if (Madd) madd_n++;
      if (Msub) msub_n++;
      if ((WriteEn || Madd || Msub) && strobe_edge < 0) strobe_edge = k + 1;
    end
    hi = WriteHiData;
    lo = WriteLoData;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (Busy !== 1'b0 || WriteEn !== 1'b0 || Madd !== 1'b0 || Msub !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy=%b we=%b madd=%b msub=%b, want all 0", Busy, WriteEn, Madd, Msub);
    end
    checks++;
    if (WriteHiData !== 32'd0 || WriteLoData !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: got hi=%h lo=%h, want 0/0", WriteHiData, WriteLoData);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  logic [2:0]  d_op [6] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd2, 3'd2};
  logic [31:0] d_a  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFF9};
  logic [31:0] d_b  [6] = '{32'hFFFF_FFFF, 32'd5, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
  logic [31:0] d_hi [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'hFFFF_FFF9};
  logic [31:0] d_lo [6] = '{32'd1, 32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

  task automatic test_directed();
    logic [31:0] hi, lo;
    int we_n, madd_n, msub_n, se, bn;
    for (int i = 0; i < 6; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], hi, lo, we_n, madd_n, msub_n, se, bn);
      checks++;
      if (hi !== d_hi[i] || lo !== d_lo[i]) begin
        errors++;
        $display("FAIL directed%0d_result: got hi=%h lo=%h, want hi=%h lo=%h", i, hi, lo, d_hi[i], d_lo[i]);
      end
      checks++;
      if (we_n != 1 || madd_n != 0 || msub_n != 0) begin
        errors++;
        $display("FAIL directed%0d_strobe: got we=%0d madd=%0d msub=%0d, want 1/0/0", i, we_n, madd_n, msub_n);
      end
      checks++;
      if (se != 34 || bn != 34) begin
        errors++;
        $display("FAIL directed%0d_latency: got strobe edge=%0d busy cycles=%0d, want 34/34", i, se, bn);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] hi, lo, a, b;
    logic [63:0] exp;
    logic [2:0] op;
    int we_n, madd_n, msub_n, se, bn, kind;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 5));
      a = pick_operand();
      b = pick_operand();
      exp = model(op, a, b);
      kind = model_kind(op);
      run_op(op, a, b, hi, lo, we_n, madd_n, msub_n, se, bn);
      checks++;
      if (hi !== exp[63:32] || lo !== exp[31:0]) begin
        errors++;
        $display("FAIL random%0d op=%0d a=%h b=%h: got %h_%h, want %h", i, op, a, b, hi, lo, exp);
      end
      checks++;
      if (we_n != (kind == 0 ? 1 : 0) || madd_n != (kind == 1 ? 1 : 0) ||
          msub_n != (kind == 2 ? 1 : 0) || se != 34 || bn != 34) begin
        errors++;
        $display("FAIL random%0d_strobe op=%0d: got we=%0d madd=%0d msub=%0d edge=%0d busy=%0d, want kind %0d at 34",
                 i, op, we_n, madd_n, msub_n, se, bn, kind);
      end
    end
  endtask

  task automatic test_macc();
    logic [31:0] hi, lo;
    int we_n, madd_n, msub_n, se, bn;
    run_op(3'b101, 32'd2, 32'd3, hi, lo, we_n, madd_n, msub_n, se, bn);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd6) begin
      errors++;
      $display("FAIL macc_result: got hi=%h lo=%h, want 0/6", hi, lo);
    end
    checks++;
`ifdef MDU_MACC_EN
    if (msub_n != 1 || we_n != 0 || madd_n != 0 || se != 34) begin
      errors++;
      $display("FAIL macc_strobe: got we=%0d madd=%0d msub=%0d edge=%0d, want 0/0/1 at 34", we_n, madd_n, msub_n, se);
    end
`else
    if (we_n != 1 || msub_n != 0 || madd_n != 0 || se != 34) begin
      errors++;
      $display("FAIL macc_strobe: got we=%0d madd=%0d msub=%0d edge=%0d, want 1/0/0 at 34", we_n, madd_n, msub_n, se);
    end
`endif
  endtask

  task automatic test_ignore_start();
    logic [63:0] exp;
    int strobes, busy_seen;
    exp = model(3'b000, 32'h0001_2345, 32'hFFFF_0010);
    @(negedge Clk);
    Start = 1'b1; Op = 3'b000; OperandA = 32'h0001_2345; OperandB = 32'hFFFF_0010;
    @(posedge Clk); #1;
    Start = 1'b0;
    strobes = 0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge Clk); #1;
      if (k == 5) begin Start = 1'b1; Op = 3'b011; OperandA = 32'd100; OperandB = 32'd7; end
      if (k == 6) Start = 1'b0;
      if (WriteEn || Madd || Msub) strobes++;
    end
    checks++;
    if (strobes != 1 || WriteHiData !== exp[63:32] || WriteLoData !== exp[31:0]) begin
      errors++;
      $display("FAIL ignore_busy_start: got %0d strobes, %h_%h; want 1, %h", strobes, WriteHiData, WriteLoData, exp);
    end
    @(negedge Clk);
    Start = 1'b1; Op = 3'b110;
    @(negedge Clk);
    Start = 1'b0;
    busy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #1;
      if (Busy || WriteEn || Madd || Msub) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin
      errors++;
      $display("FAIL reserved_op: got %0d active samples, want 0", busy_seen);
    end
  endtask

  task automatic test_reset_mid();
    int active;
    @(negedge Clk);
    Start = 1'b1; Op = 3'b001; OperandA = 32'h1234_5678; OperandB = 32'h9ABC_DEF0;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if (Busy !== 1'b0 || WriteHiData !== 32'd0 || WriteLoData !== 32'd0 || WriteEn !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b hi=%h lo=%h we=%b, want 0", Busy, WriteHiData, WriteLoData, WriteEn);
    end
    Reset_n = 1'b1;
    active = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #1;
      if (Busy || WriteEn || Madd || Msub) active++;
    end
    checks++;
    if (active != 0) begin
      errors++;
      $display("FAIL reset_mid_nostrobe: got %0d active samples, want 0", active);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp1, exp2;
    logic [31:0] first_hi, first_lo;
    int edges[$];
    logic busy_at_34;
    exp1 = model(3'b001, 32'h0000_FFFF, 32'h0001_0001);
    exp2 = model(3'b001, 32'hDEAD_BEEF, 32'h0000_0010);
    first_hi = 32'd0; first_lo = 32'd0; busy_at_34 = 1'b1;
    @(negedge Clk);
    Start = 1'b1; Op = 3'b001; OperandA = 32'h0000_FFFF; OperandB = 32'h0001_0001;
    @(posedge Clk); #1;
    OperandA = 32'hDEAD_BEEF; OperandB = 32'h0000_0010;
    for (int k = 1; k <= 72; k++) begin
      @(posedge Clk); #1;
      if (k == 36) Start = 1'b0;
      if (k == 34) busy_at_34 = Busy;
      if (WriteEn || Madd || Msub) begin
        edges.push_back(k + 1);
        if (edges.size() == 1) begin first_hi = WriteHiData; first_lo = WriteLoData; end
      end
    end
    checks++;
    if (edges.size() != 2 || edges[0] != 34 || edges[1] != 69 || busy_at_34 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_timing: got %0d strobes (first edge %0d), idle gap busy=%b; want edges 34 and 69, busy 0",
               edges.size(), (edges.size() > 0) ? edges[0] : -1, busy_at_34);
    end
    checks++;
    if (first_hi !== exp1[63:32] || first_lo !== exp1[31:0] ||
        WriteHiData !== exp2[63:32] || WriteLoData !== exp2[31:0]) begin
      errors++;
      $display("FAIL b2b_results: got %h_%h then %h_%h, want %h then %h",
               first_hi, first_lo, WriteHiData, WriteLoData, exp1, exp2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_macc();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
